// File: rtl/othello_job_scheduler.sv
// Othello job scheduler: queues solve jobs, issues them into free rotating solver slots, holds one result. Optional SCHED_PERF_EN adds issue/retire counters.
// Latency: a job issues at the earliest one cycle after it is accepted; a result is registered one cycle after retire.
// Backpressure: job_ready drops when the queue is full; a held, unaccepted result freezes the solver pipeline via pipe_enable.

module othello_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         full, empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty  = (wptr == rptr);
    assign wr_rdy = !full;
    assign rd_vld = !empty;
    assign rd_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_vld && wr_rdy) wptr <= wptr + 1'b1;
            if (rd_vld && rd_rdy) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_vld && wr_rdy) mem[wptr[AW-1:0]] <= wr_dat;
    end
endmodule

module othello_job_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 8
) (
    input  logic             iCLOCK,
    input  logic             iRESET_N,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [63:0]      job_player,
    input  logic [63:0]      job_opponent,
    input  logic [TAG_W-1:0] job_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic [7:0]       res_value,
    output logic             pipe_enable,
    output logic             pipe_valid,
    output logic [63:0]      pipe_player,
    output logic [63:0]      pipe_opponent,
    input  logic             pipe_solved,
    input  logic [2:0]       pipe_pidx,
    input  logic [7:0]       pipe_res,
    output logic [7:0]       busy_slots,
    output logic             idle
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_completed
`endif
);
    typedef struct packed {
        logic [63:0]      player;
        logic [63:0]      opponent;
        logic [TAG_W-1:0] tag;
    } job_t;

    job_t             wr_job, head;
    logic             head_vld;
    logic             retire;
    logic [TAG_W-1:0] tag_mem [8];

    assign wr_job = '{player: job_player, opponent: job_opponent, tag: job_tag};

    othello_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(job_t))
    ) u_job_fifo (
        .core_clk (iCLOCK),
        .arst_n   (iRESET_N),
        .wr_vld   (job_valid),
        .wr_rdy   (job_ready),
        .wr_dat   (wr_job),
        .rd_vld   (head_vld),
        .rd_rdy   (pipe_valid),
        .rd_dat   (head)
    );

    // A slot being retired is still busy this cycle, so issue and retire never collide.
    assign pipe_enable   = !(res_valid && !res_ready);
    assign pipe_valid    = pipe_enable && head_vld && !busy_slots[pipe_pidx];
    assign retire        = pipe_solved && pipe_enable && busy_slots[pipe_pidx];
    assign pipe_player   = head_vld ? head.player   : 64'd0;
    assign pipe_opponent = head_vld ? head.opponent : 64'd0;
    assign idle          = !head_vld && (busy_slots == 8'd0) && !res_valid;

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            busy_slots <= '0;
            res_valid  <= 1'b0;
            res_tag    <= '0;
            res_value  <= '0;
            for (int s = 0; s < 8; s++) tag_mem[s] <= '0;
        end else begin
            if (pipe_valid) begin
                busy_slots[pipe_pidx] <= 1'b1;
                tag_mem[pipe_pidx]    <= head.tag;
            end
            if (retire) begin
                busy_slots[pipe_pidx] <= 1'b0;
                res_tag               <= tag_mem[pipe_pidx];
                res_value             <= pipe_res;
                res_valid             <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            perf_issued    <= '0;
            perf_completed <= '0;
        end else begin
            if (pipe_valid) perf_issued    <= perf_issued + 32'd1;
            if (retire)     perf_completed <= perf_completed + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_othello_job_scheduler.sv
// Directed bench for othello_job_scheduler: drives the solver slot interface by hand and scoreboards results by tag.
module tb_othello_job_scheduler;
    localparam int TAG_W = 8;

    logic             iCLOCK = 1'b0;
    logic             iRESET_N;
    logic             job_valid, job_ready;
    logic [63:0]      job_player, job_opponent;
    logic [TAG_W-1:0] job_tag;
    logic             res_valid, res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [7:0]       res_value;
    logic             pipe_enable, pipe_valid;
    logic [63:0]      pipe_player, pipe_opponent;
    logic             pipe_solved;
    logic [2:0]       pipe_pidx;
    logic [7:0]       pipe_res;
    logic [7:0]       busy_slots;
    logic             idle;

    int checks = 0;
    int errors = 0;
    logic [TAG_W+7:0] sb [$];

    othello_job_scheduler #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
        .iCLOCK        (iCLOCK),
        .iRESET_N      (iRESET_N),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_player    (job_player),
        .job_opponent  (job_opponent),
        .job_tag       (job_tag),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_tag       (res_tag),
        .res_value     (res_value),
        .pipe_enable   (pipe_enable),
        .pipe_valid    (pipe_valid),
        .pipe_player   (pipe_player),
        .pipe_opponent (pipe_opponent),
        .pipe_solved   (pipe_solved),
        .pipe_pidx     (pipe_pidx),
        .pipe_res      (pipe_res),
        .busy_slots    (busy_slots),
        .idle          (idle)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
        end
    endtask

    task automatic expect_res();
        logic [TAG_W+7:0] e;
        chk("res_valid", 64'(res_valid), 64'(1));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            chk("res_tag", 64'(res_tag), 64'(e[TAG_W+7:8]));
            chk("res_value", 64'(res_value), 64'(e[7:0]));
        end
    endtask

    initial begin
        iRESET_N = 1'b0; job_valid = 1'b0; job_player = '0; job_opponent = '0; job_tag = '0;
        res_ready = 1'b1; pipe_solved = 1'b0; pipe_pidx = '0; pipe_res = '0;
        #12;
        chk("rst_job_ready", 64'(job_ready), 64'(1));
        chk("rst_pipe_enable", 64'(pipe_enable), 64'(1));
        chk("rst_pipe_valid", 64'(pipe_valid), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_busy", 64'(busy_slots), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        iRESET_N = 1'b1;
        tick();

        // Single job end to end
        job_valid = 1'b1; job_player = 64'hFFFF_FFFF_FFFF_FFFF; job_opponent = 64'd0; job_tag = 8'd5; pipe_pidx = 3'd0;
        #1;
        chk("nobypass_pipe_valid", 64'(pipe_valid), 64'(0));
        chk("empty_pipe_player", pipe_player, 64'd0);
        tick();
        job_valid = 1'b0;
        #1;
        chk("head_pipe_valid", 64'(pipe_valid), 64'(1));
        chk("head_player", pipe_player, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("head_opponent", pipe_opponent, 64'd0);
        tick();
        chk("issued_busy", 64'(busy_slots), 64'h01);
        pipe_solved = 1'b1; pipe_res = 8'd64; sb.push_back({8'd5, 8'd64});
        tick();
        pipe_solved = 1'b0;
        #1;
        chk("retired_busy", 64'(busy_slots), 64'h00);
        chk("held_idle", 64'(idle), 64'(0));
        expect_res();
        tick();
        chk("drained_res_valid", 64'(res_valid), 64'(0));
        chk("drained_idle", 64'(idle), 64'(1));

        // Fill all eight slots, slot i gets tag 10+i
        for (int i = 0; i < 8; i++) begin
            pipe_pidx = 3'(i); job_valid = 1'b1; job_tag = 8'(10 + i);
            job_player = 64'(i); job_opponent = ~64'(i);
            tick();
            job_valid = 1'b0;
            #1;
            chk("fill_pipe_valid", 64'(pipe_valid), 64'(1));
            tick();
        end
        chk("all_busy", 64'(busy_slots), 64'hFF);

        // Ninth job stays queued, then fill the queue
        pipe_pidx = 3'd0; job_valid = 1'b1; job_tag = 8'd18;
        #1;
        chk("q_ready_18", 64'(job_ready), 64'(1));
        tick();
        #1;
        chk("ninth_pipe_valid", 64'(pipe_valid), 64'(0));
        chk("ninth_busy", 64'(busy_slots), 64'hFF);
        for (int k = 19; k < 22; k++) begin
            job_tag = 8'(k);
            #1;
            chk("q_ready_fill", 64'(job_ready), 64'(1));
            tick();
        end
        job_tag = 8'd22;
        #1;
        chk("full_job_ready", 64'(job_ready), 64'(0));
        tick();
        chk("held_job_ready", 64'(job_ready), 64'(0));

        // Retire slot 3; freed slot is not reissued until the next cycle
        pipe_pidx = 3'd3; pipe_solved = 1'b1; pipe_res = 8'hFD; sb.push_back({8'd13, 8'hFD});
        #1;
        chk("retire_cycle_pipe_valid", 64'(pipe_valid), 64'(0));
        tick();
        pipe_solved = 1'b0;
        #1;
        chk("slot3_free", 64'(busy_slots), 64'hF7);
        chk("slot3_pipe_valid", 64'(pipe_valid), 64'(1));
        chk("pop_no_bypass_ready", 64'(job_ready), 64'(0));
        expect_res();
        tick();
        chk("slot3_reissued", 64'(busy_slots), 64'hFF);
        chk("after_pop_ready", 64'(job_ready), 64'(1));
        chk("after_pop_res_valid", 64'(res_valid), 64'(0));
        tick();
        job_tag = 8'd23;
        #1;
        chk("refull_job_ready", 64'(job_ready), 64'(0));
        job_valid = 1'b0;

        // Result back-pressure freezes the pipeline
        pipe_pidx = 3'd5; pipe_solved = 1'b1; pipe_res = 8'h20; res_ready = 1'b0;
        sb.push_back({8'd15, 8'h20});
        tick();
        pipe_pidx = 3'd6; pipe_res = 8'h11;
        #1;
        chk("bp_pipe_enable", 64'(pipe_enable), 64'(0));
        tick();
        pipe_pidx = 3'd5; pipe_solved = 1'b0;
        #1;
        chk("bp_ignored_solve", 64'(busy_slots), 64'hDF);
        chk("bp_pipe_valid", 64'(pipe_valid), 64'(0));
        tick();
        chk("bp_busy_frozen", 64'(busy_slots), 64'hDF);
        res_ready = 1'b1;
        #1;
        chk("release_pipe_enable", 64'(pipe_enable), 64'(1));
        chk("release_pipe_valid", 64'(pipe_valid), 64'(1));
        expect_res();
        tick();
        chk("release_busy", 64'(busy_slots), 64'hFF);
        chk("release_res_valid", 64'(res_valid), 64'(0));

        // Retire during a result handshake replaces the held result
        pipe_pidx = 3'd0; pipe_solved = 1'b1; pipe_res = 8'h01; sb.push_back({8'd10, 8'h01});
        tick();
        pipe_pidx = 3'd1; pipe_res = 8'h02;
        #1;
        expect_res();
        sb.push_back({8'd11, 8'h02});
        chk("swap_pipe_enable", 64'(pipe_enable), 64'(1));
        tick();
        pipe_solved = 1'b0;
        #1;
        expect_res();
        tick();
        chk("swap_drained", 64'(res_valid), 64'(0));
        chk("pre_reset_busy", 64'(busy_slots), 64'hFE);

        // Asynchronous reset mid-operation
        #3;
        iRESET_N = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_slots), 64'h00);
        chk("arst_res_valid", 64'(res_valid), 64'(0));
        chk("arst_job_ready", 64'(job_ready), 64'(1));
        chk("arst_pipe_valid", 64'(pipe_valid), 64'(0));
        chk("arst_pipe_player", pipe_player, 64'd0);
        chk("arst_idle", 64'(idle), 64'(1));
        #2;
        iRESET_N = 1'b1;
        tick();
        pipe_pidx = 3'd2; pipe_solved = 1'b1; pipe_res = 8'h7F;
        tick();
        pipe_solved = 1'b0;
        chk("post_rst_no_result", 64'(res_valid), 64'(0));
        chk("post_rst_busy", 64'(busy_slots), 64'h00);
        chk("post_rst_idle", 64'(idle), 64'(1));
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
